// File: rtl/shiftreg_frame_arbiter.sv
// Round-robin sequencer sharing one WIDTH x DEPTH shift chain between two requesters.
// Optional fill watchdog enabled by defining SHIFTREG_FRAME_TIMEOUT_EN.
module shiftreg_frame_arbiter #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Req0,
  input  logic             Req1,
  input  logic [WIDTH-1:0] Din0,
  input  logic [WIDTH-1:0] Din1,
  input  logic             Vld0,
  input  logic             Vld1,
  output logic             Rdy0,
  output logic             Rdy1,
  output logic [1:0]       Gnt,
  output logic [WIDTH-1:0] Sr_Din,
  output logic             Sr_Shift,
  output logic             Sr_Clear,
  output logic             Frame_Valid,
  output logic             Frame_Owner,
  input  logic             Frame_Ack,
  output logic             Timeout
);

  localparam int unsigned CW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  if (DEPTH < 2 || TIMEOUT < 1) begin : g_bad_cfg
    $error("shiftreg_frame_arbiter: DEPTH must be >= 2 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {IDLE, CLEAR, FILL, FULL} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic          last_owner;

  logic             owner;
  logic             owner_req;
  logic             owner_vld;
  logic [WIDTH-1:0] owner_din;
  logic             fill_rdy;
  logic             beat;

  // Owner mux and handshake decode from registered state/grant
  always_comb begin
    owner     = Gnt[1];
    owner_req = owner ? Req1 : Req0;
    owner_vld = owner ? Vld1 : Vld0;
    owner_din = owner ? Din1 : Din0;
    fill_rdy  = (state == FILL) && owner_req;
    beat      = fill_rdy && owner_vld;
    Rdy0        = fill_rdy && Gnt[0];
    Rdy1        = fill_rdy && Gnt[1];
    Sr_Shift    = beat;
    Sr_Din      = (state == FILL) ? owner_din : '0;
    Sr_Clear    = (state == CLEAR);
    Frame_Valid = (state == FULL);
  end

`ifdef SHIFTREG_FRAME_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] idle_cnt;
`endif

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      Gnt         <= 2'b00;
      count       <= '0;
      last_owner  <= 1'b1;
      Frame_Owner <= 1'b0;
      Timeout     <= 1'b0;
`ifdef SHIFTREG_FRAME_TIMEOUT_EN
      idle_cnt    <= '0;
`endif
    end else begin
      Timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (Req0 || Req1) begin
            state <= CLEAR;
            // On contention the requester that did not own the chain last wins
            if (Req0 && Req1) Gnt <= last_owner ? 2'b01 : 2'b10;
            else if (Req0)    Gnt <= 2'b01;
            else              Gnt <= 2'b10;
          end
        end
        CLEAR: begin
          count <= '0;
`ifdef SHIFTREG_FRAME_TIMEOUT_EN
          idle_cnt <= '0;
`endif
          state <= FILL;
        end
        FILL: begin
          if (!owner_req) begin
            state      <= IDLE;
            Gnt        <= 2'b00;
            last_owner <= owner;
          end else if (beat) begin
`ifdef SHIFTREG_FRAME_TIMEOUT_EN
            idle_cnt <= '0;
`endif
            if (count == CW'(DEPTH - 1)) begin
              state       <= FULL;
              Frame_Owner <= owner;
            end else begin
              count <= count + 1'b1;
            end
          end
`ifdef SHIFTREG_FRAME_TIMEOUT_EN
          else if (idle_cnt == TW'(TIMEOUT - 1)) begin
            state      <= IDLE;
            Gnt        <= 2'b00;
            last_owner <= owner;
            Timeout    <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
`endif
        end
        FULL: begin
          if (Frame_Ack) begin
            state      <= IDLE;
            Gnt        <= 2'b00;
            last_owner <= owner;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/shiftreg_frame_arbiter.md
Name: shiftreg_frame_arbiter

Overview:
- Round-robin arbiter/sequencer that shares one WIDTH-bit, DEPTH-stage shift chain (shiftreg16b-style) between two requesters.
- Grants the chain to one requester, clears it, and shifts in exactly DEPTH words with a valid/ready handshake.
- Flags a full frame to the downstream consumer, then holds the chain until the consumer acknowledges.
- Sits between the requesters and the shift chain's Din/shift/clear inputs.

Parameters:
- WIDTH, 16, data word width; must match the shift chain width.
- DEPTH, 8, number of chain stages, i.e. words per frame; must be >= 2.
- TIMEOUT, 16, idle cycles allowed between beats in FILL; used only when the optional feature is compiled in.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high reset.
- Req0  in  1  requester 0 wants a frame slot; level, held for the whole transfer.
- Req1  in  1  requester 1 wants a frame slot.
- Din0  in  WIDTH  requester 0 data word.
- Din1  in  WIDTH  requester 1 data word.
- Vld0  in  1  Din0 valid.
- Vld1  in  1  Din1 valid.
- Rdy0  out  1  word accepted from requester 0 when Vld0 & Rdy0.
- Rdy1  out  1  word accepted from requester 1 when Vld1 & Rdy1.
- Gnt  out  2  one-hot current owner; 00 when none.
- Sr_Din  out  WIDTH  data to the chain's Din input.
- Sr_Shift  out  1  chain shift enable.
- Sr_Clear  out  1  one-cycle synchronous clear to the chain.
- Frame_Valid  out  1  chain holds DEPTH words from the owner.
- Frame_Owner  out  1  index of the requester that filled the frame.
- Frame_Ack  in  1  consumer done with the frame.
- Timeout  out  1  one-cycle pulse on a watchdog abort.

Behaviour:
- States: IDLE, CLEAR, FILL, FULL. Registered state, beat counter, last_owner and Gnt.
- Reset (async, immediate): state=IDLE, Gnt=00, count=0, last_owner=1 (so requester 0 wins first), Frame_Owner=0.
- Reset output values: Rdy0/1, Sr_Shift, Sr_Clear, Frame_Valid and Timeout all 0; Sr_Din=0.
- IDLE:
  - If any Req is high, go to CLEAR and load Gnt next cycle.
  - Single request: grant that requester.
  - Both requests: grant the requester != last_owner.
- CLEAR: Sr_Clear=1 for exactly one cycle; count=0; go to FILL.
- FILL:
  - Rdy of the owner is 1; the other Rdy is 0. Rdy is decoded from registered state/Gnt.
  - Sr_Din = owner's Din; Sr_Shift = owner's Vld (a beat).
  - Each beat increments count. The beat with count==DEPTH-1 moves to FULL.
  - Sr_Din=0 whenever not in FILL.
- FULL:
  - Frame_Valid=1, Frame_Owner=owner, no shifts, both Rdy=0.
  - Frame_Ack moves to IDLE next cycle, sets last_owner=owner, Gnt=00.
  - Frame_Ack in any other state is ignored.
- Abort: owner's Req low while in FILL → IDLE next cycle.
  - Gnt=00, last_owner=owner, no Frame_Valid.
  - A beat presented in that same cycle is not shifted: Rdy is forced 0 while Req is low.
  - Partial chain contents are discarded by the next CLEAR.
- Non-owner Req/Vld are ignored in CLEAR/FILL/FULL; no preemption.
- Latency:
  - Req rise at edge t → CLEAR during t+1 → first possible beat at t+2.
  - Minimum frame time is DEPTH+2 cycles to Frame_Valid.
- Mid-operation Reset: everything returns to reset values immediately. The chain is not cleared until the next CLEAR.

Optional Feature:
- Macro: SHIFTREG_FRAME_TIMEOUT_EN.
- Defined:
  - A watchdog counts consecutive FILL cycles without a beat; any beat resets it.
  - When it reaches TIMEOUT: Timeout=1 for one cycle, abort to IDLE exactly as for a Req drop, last_owner=owner.
- Undefined: no watchdog logic; Timeout tied to 0; FILL waits indefinitely.

Test Plan:
1. Single requester fill:
   - Stimulus: after Reset, Req0=1, Vld0 held high, Din0=0x0011,0x0022,...,0x0088.
   - Response: Sr_Clear one cycle, then exactly 8 Sr_Shift. Frame_Valid=1 with Frame_Owner=0 at cycle 10 after Req. Holds until Frame_Ack; Gnt=00 the cycle after the ack.
2. Round-robin fairness:
   - Stimulus: Req0=Req1=1 from reset; complete and ack each frame.
   - Response: grant order 01,10,01,10; Frame_Owner alternates 0,1,0,1.
3. Handshake gaps:
   - Stimulus: Vld1 toggles 1,0,0,1,... with Din1=0xA000+n.
   - Response: Sr_Shift only on Vld1 & Rdy1, still exactly 8 shifts, words in order; Rdy0 stays 0 throughout.
4. Abort:
   - Stimulus: Req0 dropped after 3 beats while Req1=1.
   - Response: IDLE, no Frame_Valid; next grant goes to requester 1 with Sr_Clear before its first shift.
5. Async reset mid-FILL:
   - Stimulus: Reset pulsed high after 5 beats, away from the clock edge.
   - Response: Gnt=00, Rdy=0, Sr_Shift=0 immediately; the next request restarts from CLEAR with count=0.
6. Watchdog (macro defined, TIMEOUT=16):
   - Stimulus: owner stalls with Vld=0 for 16 cycles.
   - Response: Timeout pulses once, IDLE; with the macro undefined, FILL persists and Timeout stays 0.
